// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the RAM arbiter slice:
//   - master_e : requester IDs (RT=0 router, CP=1, COM=2)
//   - state_e  : issue FSM states (IDLE, ISSUE, RD_WAIT)
//   - WORD_BYTES, SUPPORTED_RD_LAT
//   - lane helpers used to map byte masters onto the 32-bit RAM word
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        RT  = 2'd0,
        CP  = 2'd1,
        COM = 2'd2
    } master_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_e;

    localparam int WORD_BYTES       = 4;
    localparam int SUPPORTED_RD_LAT = 1;
    localparam int LANE_W           = $clog2(WORD_BYTES);

    // One-hot byte write enable for a byte lane.
    function automatic logic [3:0] lane_strb(input logic [LANE_W-1:0] lane);
        logic [3:0] strb;
        case (lane)
            2'd0:    strb = 4'b0001;
            2'd1:    strb = 4'b0010;
            2'd2:    strb = 4'b0100;
            2'd3:    strb = 4'b1000;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Extract one byte lane from a RAM word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [LANE_W-1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the three master request channels and the single RAM port.
//   slave  modport : the arbiter view (takes requests, drives the RAM)
//   master modport : the requester/RAM view (drives requests and mem_rdata)
// Router: 32-bit data with byte strobes. CP/COM: 8-bit data.
// ---------------------------------------------------------------------------
interface ram_arbiter_if;

    // router channel
    logic        rt_req;
    logic        rt_we;
    logic [31:0] rt_addr;
    logic [31:0] rt_wdata;
    logic [3:0]  rt_wstrb;
    logic        rt_gnt;
    logic        rt_rvalid;
    logic [31:0] rt_rdata;

    // CP channel
    logic        cp_req;
    logic        cp_we;
    logic [31:0] cp_addr;
    logic [7:0]  cp_wdata;
    logic        cp_gnt;
    logic        cp_rvalid;
    logic [7:0]  cp_rdata;

    // COM channel
    logic        com_req;
    logic        com_we;
    logic [31:0] com_addr;
    logic [7:0]  com_wdata;
    logic        com_gnt;
    logic        com_rvalid;
    logic [7:0]  com_rdata;

    // RAM port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;

    modport slave (
        input  rt_req, rt_we, rt_addr, rt_wdata, rt_wstrb,
        output rt_gnt, rt_rvalid, rt_rdata,
        input  cp_req, cp_we, cp_addr, cp_wdata,
        output cp_gnt, cp_rvalid, cp_rdata,
        input  com_req, com_we, com_addr, com_wdata,
        output com_gnt, com_rvalid, com_rdata,
        output mem_addr, mem_wdata, mem_wen, mem_ren,
        input  mem_rdata
    );

    modport master (
        output rt_req, rt_we, rt_addr, rt_wdata, rt_wstrb,
        input  rt_gnt, rt_rvalid, rt_rdata,
        output cp_req, cp_we, cp_addr, cp_wdata,
        input  cp_gnt, cp_rvalid, cp_rdata,
        output com_req, com_we, com_addr, com_wdata,
        input  com_gnt, com_rvalid, com_rdata,
        input  mem_addr, mem_wdata, mem_wen, mem_ren,
        output mem_rdata
    );

endinterface

// File: rtl/ram_arb_pick.sv
// ---------------------------------------------------------------------------
// ram_arb_pick
// Combinational winner selection among the three masters.
//   i_req[2:0]  : request vector, bit index = master_e (RT, CP, COM)
//   i_last[1:0] : last granted master (round-robin pointer)
//   o_win[2:0]  : one-hot winner, all zero when nothing is requested
// Macro RAM_ARB_RR_EN: defined -> round-robin starting after i_last;
// undefined -> fixed priority RT > CP > COM and i_last is ignored.
// ---------------------------------------------------------------------------
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last,
    output logic [2:0] o_win
);

`ifdef RAM_ARB_RR_EN
    // Round-robin: search order starts at the master after the last winner.
    always_comb begin
        o_win = 3'b000;
        case (i_last)
            2'd0: begin // last RT -> CP, COM, RT
                if (i_req[1])      o_win = 3'b010;
                else if (i_req[2]) o_win = 3'b100;
                else if (i_req[0]) o_win = 3'b001;
                else               o_win = 3'b000;
            end
            2'd1: begin // last CP -> COM, RT, CP
                if (i_req[2])      o_win = 3'b100;
                else if (i_req[0]) o_win = 3'b001;
                else if (i_req[1]) o_win = 3'b010;
                else               o_win = 3'b000;
            end
            default: begin // last COM -> RT, CP, COM
                if (i_req[0])      o_win = 3'b001;
                else if (i_req[1]) o_win = 3'b010;
                else if (i_req[2]) o_win = 3'b100;
                else               o_win = 3'b000;
            end
        endcase
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_last;

    // Fixed priority: router first, then CP, then COM.
    always_comb begin
        o_win = 3'b000;
        if (i_req[0])      o_win = 3'b001;
        else if (i_req[1]) o_win = 3'b010;
        else if (i_req[2]) o_win = 3'b100;
        else               o_win = 3'b000;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Front-end of the shared 32-bit data RAM. Serialises router (32-bit), CP
// (8-bit) and COM (8-bit) requests onto one RAM port using a req/gnt
// handshake and a fixed IDLE -> ISSUE (-> RD_WAIT) pipeline, expands byte
// requests into lane strobes and returns read data to the issuing master.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_arbiter_if.slave (master channels + RAM port)
// Parameters:
//   DEPTH  : number of RAM words; word index = addr[31:2]
//   RD_LAT : RAM read latency, only 1 is supported
// Macro RAM_ARB_RR_EN: round-robin arbitration instead of fixed priority.
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    generate
        if (RD_LAT != SUPPORTED_RD_LAT) begin : g_bad_rd_lat
            $error("ram_arbiter: only RD_LAT=1 is supported");
        end
    endgenerate

    // ------------------------------------------------------------------
    // registers
    // ------------------------------------------------------------------
    state_e      r_state;
    master_e     r_owner;
    logic        r_is_rd;
    logic        r_oor;
    logic [1:0]  r_lane;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wen;
    logic        r_mem_ren;
    logic        r_rt_gnt, r_cp_gnt, r_com_gnt;
    logic        r_rt_rvalid, r_cp_rvalid, r_com_rvalid;
    logic [31:0] r_rt_rdata;
    logic [7:0]  r_cp_rdata, r_com_rdata;

    // ------------------------------------------------------------------
    // next-state wires
    // ------------------------------------------------------------------
    state_e      w_state_nxt;
    master_e     w_owner_nxt;
    logic        w_is_rd_nxt;
    logic        w_oor_nxt;
    logic [1:0]  w_lane_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [3:0]  w_mem_wen_nxt;
    logic        w_mem_ren_nxt;
    logic        w_rt_gnt_nxt, w_cp_gnt_nxt, w_com_gnt_nxt;
    logic        w_rt_rvalid_nxt, w_cp_rvalid_nxt, w_com_rvalid_nxt;
    logic [31:0] w_rt_rdata_nxt;
    logic [7:0]  w_cp_rdata_nxt, w_com_rdata_nxt;

    logic [2:0]  w_req;
    logic [2:0]  w_win;
    logic [1:0]  w_last;
    master_e     w_sel_id;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_strb;
    logic        w_sel_oor;
    logic [31:0] w_rd_word;

    assign w_req = {bus.com_req, bus.cp_req, bus.rt_req};

`ifdef RAM_ARB_RR_EN
    logic [1:0] r_last;

    // Last-winner pointer, updated while the granted command is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 2'd0;
        end else if (r_state == ST_ISSUE) begin
            r_last <= r_owner;
        end else begin
            r_last <= r_last;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 2'd0;
`endif

    ram_arb_pick u_pick (
        .i_req  (w_req),
        .i_last (w_last),
        .o_win  (w_win)
    );

    // Steer the winning master's command onto a common 32-bit form; byte
    // masters replicate their data to all lanes and strobe only their lane.
    always_comb begin
        w_sel_id    = RT;
        w_sel_we    = bus.rt_we;
        w_sel_addr  = bus.rt_addr;
        w_sel_wdata = bus.rt_wdata;
        w_sel_strb  = bus.rt_wstrb;
        if (w_win[1]) begin
            w_sel_id    = CP;
            w_sel_we    = bus.cp_we;
            w_sel_addr  = bus.cp_addr;
            w_sel_wdata = {4{bus.cp_wdata}};
            w_sel_strb  = lane_strb(bus.cp_addr[1:0]);
        end else if (w_win[2]) begin
            w_sel_id    = COM;
            w_sel_we    = bus.com_we;
            w_sel_addr  = bus.com_addr;
            w_sel_wdata = {4{bus.com_wdata}};
            w_sel_strb  = lane_strb(bus.com_addr[1:0]);
        end else begin
            w_sel_id    = RT;
            w_sel_we    = bus.rt_we;
            w_sel_addr  = bus.rt_addr;
            w_sel_wdata = bus.rt_wdata;
            w_sel_strb  = bus.rt_wstrb;
        end
    end

    assign w_sel_oor = (w_sel_addr[31:2] >= 30'(DEPTH));

    // Out-of-range reads never strobe the RAM, so return zero instead.
    assign w_rd_word = r_oor ? 32'h0000_0000 : bus.mem_rdata;

    // Issue FSM next-state and next values of every registered output.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_is_rd_nxt      = r_is_rd;
        w_oor_nxt        = r_oor;
        w_lane_nxt       = r_lane;
        w_mem_addr_nxt   = 32'h0000_0000;
        w_mem_wdata_nxt  = 32'h0000_0000;
        w_mem_wen_nxt    = 4'b0000;
        w_mem_ren_nxt    = 1'b0;
        w_rt_gnt_nxt     = 1'b0;
        w_cp_gnt_nxt     = 1'b0;
        w_com_gnt_nxt    = 1'b0;
        w_rt_rvalid_nxt  = 1'b0;
        w_cp_rvalid_nxt  = 1'b0;
        w_com_rvalid_nxt = 1'b0;
        w_rt_rdata_nxt   = r_rt_rdata;
        w_cp_rdata_nxt   = r_cp_rdata;
        w_com_rdata_nxt  = r_com_rdata;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_owner_nxt     = w_sel_id;
                    w_is_rd_nxt     = ~w_sel_we;
                    w_oor_nxt       = w_sel_oor;
                    w_lane_nxt      = w_sel_addr[1:0];
                    w_mem_addr_nxt  = {2'b00, w_sel_addr[31:2]};
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_mem_wen_nxt   = (w_sel_we && !w_sel_oor) ? w_sel_strb : 4'b0000;
                    w_mem_ren_nxt   = ~w_sel_we & ~w_sel_oor;
                    w_rt_gnt_nxt    = w_win[0];
                    w_cp_gnt_nxt    = w_win[1];
                    w_com_gnt_nxt   = w_win[2];
                    w_state_nxt     = ST_ISSUE;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // No arbitration here: the granted master is dropping req now.
                if (r_is_rd) begin
                    w_state_nxt = ST_RD_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                w_state_nxt = ST_IDLE;
                case (r_owner)
                    RT: begin
                        w_rt_rdata_nxt  = w_rd_word;
                        w_rt_rvalid_nxt = 1'b1;
                    end
                    CP: begin
                        w_cp_rdata_nxt  = lane_byte(w_rd_word, r_lane);
                        w_cp_rvalid_nxt = 1'b1;
                    end
                    default: begin
                        w_com_rdata_nxt  = lane_byte(w_rd_word, r_lane);
                        w_com_rvalid_nxt = 1'b1;
                    end
                endcase
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command, handshake and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= RT;
            r_is_rd      <= 1'b0;
            r_oor        <= 1'b0;
            r_lane       <= 2'd0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_wen    <= 4'b0000;
            r_mem_ren    <= 1'b0;
            r_rt_gnt     <= 1'b0;
            r_cp_gnt     <= 1'b0;
            r_com_gnt    <= 1'b0;
            r_rt_rvalid  <= 1'b0;
            r_cp_rvalid  <= 1'b0;
            r_com_rvalid <= 1'b0;
            r_rt_rdata   <= 32'h0000_0000;
            r_cp_rdata   <= 8'h00;
            r_com_rdata  <= 8'h00;
        end else begin
            r_owner      <= w_owner_nxt;
            r_is_rd      <= w_is_rd_nxt;
            r_oor        <= w_oor_nxt;
            r_lane       <= w_lane_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wen    <= w_mem_wen_nxt;
            r_mem_ren    <= w_mem_ren_nxt;
            r_rt_gnt     <= w_rt_gnt_nxt;
            r_cp_gnt     <= w_cp_gnt_nxt;
            r_com_gnt    <= w_com_gnt_nxt;
            r_rt_rvalid  <= w_rt_rvalid_nxt;
            r_cp_rvalid  <= w_cp_rvalid_nxt;
            r_com_rvalid <= w_com_rvalid_nxt;
            r_rt_rdata   <= w_rt_rdata_nxt;
            r_cp_rdata   <= w_cp_rdata_nxt;
            r_com_rdata  <= w_com_rdata_nxt;
        end
    end

    assign bus.rt_gnt     = r_rt_gnt;
    assign bus.rt_rvalid  = r_rt_rvalid;
    assign bus.rt_rdata   = r_rt_rdata;
    assign bus.cp_gnt     = r_cp_gnt;
    assign bus.cp_rvalid  = r_cp_rvalid;
    assign bus.cp_rdata   = r_cp_rdata;
    assign bus.com_gnt    = r_com_gnt;
    assign bus.com_rvalid = r_com_rvalid;
    assign bus.com_rdata  = r_com_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wen    = r_mem_wen;
    assign bus.mem_ren    = r_mem_ren;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter with a small 32-word RAM stand-in.
// Expected values are hand-computed from the address map and lane rules.
// Honours RAM_ARB_RR_EN for the simultaneous-request grant order.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    // RAM stand-in preload port
    logic        pre_en;
    logic [4:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] ram [0:31];

    ram_arbiter_if bus ();

    ram_arbiter #(.DEPTH(32), .RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stand-in: 1-cycle read latency, byte-enabled writes, preload port.
    always @(posedge clk) begin
        if (pre_en) ram[pre_idx] <= pre_val;
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr[4:0]];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wen[b]) ram[bus.mem_addr[4:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic ram_load(input logic [4:0] idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic set_req(input int m, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
        case (m)
            0: begin
                bus.rt_req = req; bus.rt_we = we; bus.rt_addr = addr;
                bus.rt_wdata = wdata; bus.rt_wstrb = wstrb;
            end
            1: begin
                bus.cp_req = req; bus.cp_we = we; bus.cp_addr = addr;
                bus.cp_wdata = wdata[7:0];
            end
            default: begin
                bus.com_req = req; bus.com_we = we; bus.com_addr = addr;
                bus.com_wdata = wdata[7:0];
            end
        endcase
    endtask

    function automatic logic get_gnt(input int m);
        if (m == 0) return bus.rt_gnt;
        else if (m == 1) return bus.cp_gnt;
        else return bus.com_gnt;
    endfunction

    function automatic logic get_rvalid(input int m);
        if (m == 0) return bus.rt_rvalid;
        else if (m == 1) return bus.cp_rvalid;
        else return bus.com_rvalid;
    endfunction

    function automatic logic [31:0] get_rdata(input int m);
        if (m == 0) return bus.rt_rdata;
        else if (m == 1) return {24'h0, bus.cp_rdata};
        else return {24'h0, bus.com_rdata};
    endfunction

    // One single-master transaction with checks on the ISSUE cycle and rvalid timing.
    task automatic txn(input string tag, input int m, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] e_maddr,
                       input logic [31:0] e_mwdata, input logic [3:0] e_wen,
                       input logic e_ren, input logic [31:0] e_rdata);
        int lat;
        lat = 0;
        set_req(m, 1'b1, we, addr, wdata, wstrb);
        do begin
            tick();
            lat++;
        end while (!get_gnt(m) && lat < 8);
        chk({tag, " gnt_lat"}, 32'(lat), 32'd1);
        chk({tag, " mem_addr"}, bus.mem_addr, e_maddr);
        if (we) chk({tag, " mem_wdata"}, bus.mem_wdata, e_mwdata);
        chk({tag, " mem_wen"}, 32'(bus.mem_wen), 32'(e_wen));
        chk({tag, " mem_ren"}, 32'(bus.mem_ren), 32'(e_ren));
        set_req(m, 1'b0, we, addr, wdata, wstrb);
        if (!we) begin
            tick();
            chk({tag, " rvalid_early"}, 32'(get_rvalid(m)), 32'd0);
            tick();
            chk({tag, " rvalid"}, 32'(get_rvalid(m)), 32'd1);
            chk({tag, " rdata"}, get_rdata(m), e_rdata);
            tick();
            chk({tag, " rvalid_drop"}, 32'(get_rvalid(m)), 32'd0);
            chk({tag, " rdata_hold"}, get_rdata(m), e_rdata);
        end else begin
            tick();
            chk({tag, " gnt_drop"}, 32'(get_gnt(m)), 32'd0);
            chk({tag, " wen_drop"}, 32'(bus.mem_wen), 32'd0);
        end
    endtask

    initial begin : main
        int          g_cyc [3];
        int          v_cyc [3];
        int          v_cnt [3];
        logic [31:0] v_dat [3];
        int          e_g [3];
        logic [31:0] s_addr [3];
        logic [31:0] e_dat [3];

        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        pre_en  = 1'b0;
        pre_idx = 5'd0;
        pre_val = 32'h0;
        bus.mem_rdata = 32'h0;
        for (int m = 0; m < 3; m++) set_req(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        // reset state
        chk("rst rt_gnt", 32'(bus.rt_gnt), 32'd0);
        chk("rst mem_ren", 32'(bus.mem_ren), 32'd0);
        chk("rst mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst rt_rdata", bus.rt_rdata, 32'd0);
        chk("rst cp_rvalid", 32'(bus.cp_rvalid), 32'd0);
        for (int i = 0; i < 32; i++) ram_load(5'(i), 32'h0);
        rst_n = 1'b1;
        tick();

        // router write then read of word 4
        txn("rt_wr", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h4, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        txn("rt_rd", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);

        // CP byte write to lane 3 of a zeroed word, then readback
        ram_load(5'd4, 32'h0);
        txn("cp_wr", 1, 1'b1, 32'h13, 32'hA5, 4'h0, 32'h4, 32'hA5A5A5A5, 4'b1000, 1'b0, 32'h0);
        txn("cp_rd", 1, 1'b0, 32'h13, 32'h0, 4'h0, 32'h4, 32'h0, 4'h0, 1'b1, 32'hA5);

        // COM byte write to lane 1 of word 8, readback, full-word view
        txn("com_wr", 2, 1'b1, 32'h21, 32'h5C, 4'h0, 32'h8, 32'h5C5C5C5C, 4'b0010, 1'b0, 32'h0);
        txn("com_rd", 2, 1'b0, 32'h21, 32'h0, 4'h0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h5C);
        txn("rt_rd8", 0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h00005C00);

        // router write with no strobes leaves word 4 untouched
        txn("rt_wr0", 0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h4, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
        txn("rt_rd4", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 32'h0, 4'h0, 1'b1, 32'hA5000000);

        // out of range: word 128
        txn("oor_rd", 0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0);
        txn("oor_wr", 0, 1'b1, 32'h200, 32'h12345678, 4'hF, 32'h80, 32'h12345678, 4'h0, 1'b0, 32'h0);
        txn("oor_cp", 1, 1'b0, 32'h201, 32'h0, 4'h0, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0);

        // leave the router as last winner before the contention test
        txn("rt_last", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 32'h0, 4'h0, 1'b1, 32'hA5000000);

        // three simultaneous reads
        s_addr[0] = 32'h10; e_dat[0] = 32'hA5000000;
        s_addr[1] = 32'h21; e_dat[1] = 32'h5C;
        s_addr[2] = 32'h13; e_dat[2] = 32'hA5;
`ifdef RAM_ARB_RR_EN
        e_g[0] = 7; e_g[1] = 1; e_g[2] = 4;
`else
        e_g[0] = 1; e_g[1] = 4; e_g[2] = 7;
`endif
        for (int m = 0; m < 3; m++) begin
            g_cyc[m] = 0; v_cyc[m] = 0; v_cnt[m] = 0; v_dat[m] = 32'h0;
            set_req(m, 1'b1, 1'b0, s_addr[m], 32'h0, 4'h0);
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                if (get_gnt(m)) begin
                    g_cyc[m] = c;
                    set_req(m, 1'b0, 1'b0, s_addr[m], 32'h0, 4'h0);
                end
                if (get_rvalid(m)) begin
                    v_cyc[m] = c;
                    v_cnt[m]++;
                    v_dat[m] = get_rdata(m);
                end
            end
        end
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("sim gnt_cyc m%0d", m), 32'(g_cyc[m]), 32'(e_g[m]));
            chk($sformatf("sim rv_cyc m%0d", m), 32'(v_cyc[m]), 32'(e_g[m] + 2));
            chk($sformatf("sim rv_cnt m%0d", m), 32'(v_cnt[m]), 32'd1);
            chk($sformatf("sim rdata m%0d", m), v_dat[m], e_dat[m]);
        end

        // reset during RD_WAIT of a COM read; held request is regranted
        set_req(2, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
        tick();
        chk("rst_mid gnt", 32'(bus.com_gnt), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid com_rdata", 32'(bus.com_rdata), 32'd0);
        chk("rst_mid mem_ren", 32'(bus.mem_ren), 32'd0);
        chk("rst_mid com_gnt", 32'(bus.com_gnt), 32'd0);
        tick();
        chk("rst_mid no_rvalid", 32'(bus.com_rvalid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("regrant gnt", 32'(bus.com_gnt), 32'd1);
        chk("regrant ren", 32'(bus.mem_ren), 32'd1);
        chk("regrant addr", bus.mem_addr, 32'h4);
        set_req(2, 1'b0, 1'b0, 32'h13, 32'h0, 4'h0);
        tick();
        tick();
        chk("regrant rvalid", 32'(bus.com_rvalid), 32'd1);
        chk("regrant rdata", 32'(bus.com_rdata), 32'hA5);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
